rect_bounce_draw: RTL and testbench

Frame-buffer draw source that paints a solid-colour rectangle into the back buffer and moves it each frame with edge bounce. It connects to the frame manager's shared write bus as one more source next to the background and starfield sources. It paints one pixel per clock whenever the manager grants its source ID. Position is updated once per `frame` pulse, with speed taken from the wheel.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/rect_motion.sv | 48 ++++
 rtl/rect_bounce_draw.sv | 112 +++++++++++
 tb/tb_rect_bounce_draw.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: screen geometry, colour and coordinate types,
// writer IDs, and the edge-bounce step used by moving sources.
package fb_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int COLOR_DEPTH = 9;

   typedef logic [COLOR_DEPTH-1:0] color_t;
   typedef logic [10:0]            xcoord_t;
   typedef logic [9:0]             ycoord_t;

   localparam int SRC_BACKGROUND = 0;
   localparam int SRC_STARFIELD  = 1;
   localparam int SRC_RECT       = 2;

   typedef enum logic [1:0] {IDLE, DRAW, DONE} draw_state_t;

   // Returns {next_dir, next_pos}; the guard bit in 'up' keeps pos+speed from wrapping.
   function automatic logic [11:0] bounce_step(input logic [10:0] pos,
                                               input logic        dir,
                                               input logic [3:0]  speed,
                                               input logic [10:0] max_pos);
      logic [11:0] up;
      up = {1'b0, pos} + {8'd0, speed};
      if (speed == 4'd0) begin
         bounce_step = {dir, pos};
      end else if (dir) begin
         if (up >= {1'b0, max_pos}) bounce_step = {1'b0, max_pos};
         else                       bounce_step = {1'b1, up[10:0]};
      end else begin
         if (pos <= {7'd0, speed})  bounce_step = {1'b1, 11'd0};
         else                       bounce_step = {1'b0, pos - {7'd0, speed}};
      end
   endfunction

endpackage

// File: rtl/rect_motion.sv
// Rectangle position and direction registers; moves by 'speed' pixels on each
// frame pulse and bounces off the screen edges.
module rect_motion
   import fb_pkg::*;
#(
   parameter int RECT_W   = 32,
   parameter int RECT_H   = 24,
   parameter int SCREEN_W = fb_pkg::SCREEN_W,
   parameter int SCREEN_H = fb_pkg::SCREEN_H,
   parameter int START_X  = 0,
   parameter int START_Y  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame,
   input  logic [3:0] speed,
   output xcoord_t    pos_x,
   output ycoord_t    pos_y
);

   localparam xcoord_t MAXX = xcoord_t'(SCREEN_W - RECT_W);
   localparam xcoord_t MAXY = xcoord_t'(SCREEN_H - RECT_H);

   logic        dx;
   logic        dy;
   logic [11:0] step_x;
   logic [11:0] step_y;
   logic        unused_step_y;

   assign step_x        = bounce_step(pos_x, dx, speed, MAXX);
   assign step_y        = bounce_step({1'b0, pos_y}, dy, speed, MAXY);
   assign unused_step_y = step_y[10];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_x <= xcoord_t'(START_X);
         pos_y <= ycoord_t'(START_Y);
         dx    <= 1'b1;
         dy    <= 1'b1;
      end else if (frame) begin
         pos_x <= step_x[10:0];
         dx    <= step_x[11];
         pos_y <= step_y[9:0];
         dy    <= step_y[11];
      end
   end

endmodule

// File: rtl/rect_bounce_draw.sv
// Frame-buffer write source that paints a solid rectangle, one pixel per granted
// clock, at an origin snapshotted from the bouncing position when the paint starts.
module rect_bounce_draw
   import fb_pkg::*;
#(
   parameter int                     SOURCE_ID   = fb_pkg::SRC_RECT,
   parameter int                     SEL_WIDTH   = 1,
   parameter int                     COLOR_DEPTH = fb_pkg::COLOR_DEPTH,
   parameter logic [COLOR_DEPTH-1:0] RECT_COLOR  = 9'b111000000,
   parameter int                     RECT_W      = 32,
   parameter int                     RECT_H      = 24,
   parameter int                     SCREEN_W    = fb_pkg::SCREEN_W,
   parameter int                     SCREEN_H    = fb_pkg::SCREEN_H,
   parameter int                     START_X     = 0,
   parameter int                     START_Y     = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame,
   input  logic [11:0]            Wheel,
   input  logic [SEL_WIDTH-1:0]   write_source_sel,
   input  logic                   write_awaited,
   output logic                   write_active,
   output logic [COLOR_DEPTH-1:0] write_color_data,
   output logic [31:0]            write_x_addr,
   output logic [31:0]            write_y_addr
);

   draw_state_t state;
   draw_state_t state_nxt;
   xcoord_t     pos_x, org_x, cx, pix_x;
   ycoord_t     pos_y, org_y, cy, pix_y;
   logic        granted;
   logic        last_col;
   logic        last_row;
   logic        unused_wheel;

   rect_motion #(
      .RECT_W   (RECT_W),
      .RECT_H   (RECT_H),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .START_X  (START_X),
      .START_Y  (START_Y)
   ) u_motion (
      .clk   (clk),
      .reset (reset),
      .frame (frame),
      .speed (Wheel[11:8]),
      .pos_x (pos_x),
      .pos_y (pos_y)
   );

   // Full-width compare: an ID that does not fit in SEL_WIDTH is simply never granted.
   assign granted      = (int'(write_source_sel) == SOURCE_ID) && write_awaited;
   assign last_col     = (cx == xcoord_t'(RECT_W - 1));
   assign last_row     = (cy == ycoord_t'(RECT_H - 1));
   assign unused_wheel = ^Wheel[7:0];

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path infers a latch.
      state_nxt        = state;
      write_active     = 1'b0;
      write_color_data = '0;
      pix_x            = '0;
      pix_y            = '0;
      case (state)
         IDLE: if (granted) state_nxt = DRAW;
         DRAW: begin
            if (granted) begin
               write_active     = 1'b1;
               write_color_data = RECT_COLOR;
               pix_x            = org_x + cx;
               pix_y            = org_y + cy;
               if (last_col && last_row) state_nxt = DONE;
            end
         end
         DONE:    if (!granted) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign write_x_addr = {21'd0, pix_x};
   assign write_y_addr = {22'd0, pix_y};

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking updates so every register samples pre-edge values (org_* gets the old pos_*).
      if (reset) begin
         state <= IDLE;
         org_x <= '0;
         org_y <= '0;
         cx    <= '0;
         cy    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && granted) begin
            org_x <= pos_x;
            org_y <= pos_y;
            cx    <= '0;
            cy    <= '0;
         end else if (write_active) begin
            if (last_col) begin
               cx <= '0;
               cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rect_bounce_draw.sv
// Directed bench for rect_bounce_draw: instance A (640x480) for painting behaviour,
// instance B (20x10 screen) for edge bounce, both with a 4x2 rectangle at (10,5).
module tb_rect_bounce_draw;

   localparam logic [8:0] RC   = 9'b111000000;
   localparam logic [1:0] ID_A = 2'd2;
   localparam logic [1:0] ID_B = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_a, frame_b;
   logic [11:0] wheel_a, wheel_b;
   logic [1:0]  sel;
   logic        awaited;
   logic        act_a, act_b;
   logic [8:0]  col_a, col_b;
   logic [31:0] xa, ya, xb, yb;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [73:0] cap_bus [8];
   int          cap_n;
   int          cap_first;

   always #5 clk = ~clk;

   rect_bounce_draw #(
      .SOURCE_ID (2), .SEL_WIDTH (2), .COLOR_DEPTH (9), .RECT_COLOR (RC),
      .RECT_W (4), .RECT_H (2), .SCREEN_W (640), .SCREEN_H (480),
      .START_X (10), .START_Y (5)
   ) dut_a (
      .clk (clk), .reset (reset), .frame (frame_a), .Wheel (wheel_a),
      .write_source_sel (sel), .write_awaited (awaited),
      .write_active (act_a), .write_color_data (col_a),
      .write_x_addr (xa), .write_y_addr (ya)
   );

   rect_bounce_draw #(
      .SOURCE_ID (3), .SEL_WIDTH (2), .COLOR_DEPTH (9), .RECT_COLOR (RC),
      .RECT_W (4), .RECT_H (2), .SCREEN_W (20), .SCREEN_H (10),
      .START_X (10), .START_Y (5)
   ) dut_b (
      .clk (clk), .reset (reset), .frame (frame_b), .Wheel (wheel_b),
      .write_source_sel (sel), .write_awaited (awaited),
      .write_active (act_b), .write_color_data (col_b),
      .write_x_addr (xb), .write_y_addr (yb)
   );

   function automatic logic [73:0] bus_a();
      return {act_a, col_a, xa, ya};
   endfunction

   function automatic logic [73:0] bus_b();
      return {act_b, col_b, xb, yb};
   endfunction

   function automatic logic [73:0] pix(input int x, input int y);
      return {1'b1, RC, 32'(x), 32'(y)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Grants one source until 8 pixels are seen (bounded), then releases the grant.
   task automatic capture(input logic [1:0] id);
      logic [73:0] obs;
      cap_n     = 0;
      cap_first = -1;
      for (int k = 0; k < 8; k++) cap_bus[k] = '0;
      sel     = id;
      awaited = 1'b1;
      for (int c = 0; c < 40 && cap_n < 8; c++) begin
         #1;
         obs = (id == ID_A) ? bus_a() : bus_b();
         if (obs[73]) begin
            if (cap_n == 0) cap_first = c;
            cap_bus[cap_n] = obs;
            cap_n++;
         end
         tick();
      end
      awaited = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulse_b(input logic [3:0] s);
      wheel_b = {s, 8'hA5};
      frame_b = 1'b1;
      tick();
      frame_b = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; sel = ID_A; awaited = 1'b1;
      frame_a = 1'b0; frame_b = 1'b0; wheel_a = '0; wheel_b = '0;
      tick(); tick();
      tests_run++;
      if (bus_a() !== '0) begin
         tests_failed++;
         $display("FAIL reset_bus_a: got %h expected 0", bus_a());
      end
      sel = ID_B; #1;
      tests_run++;
      if (bus_b() !== '0) begin
         tests_failed++;
         $display("FAIL reset_bus_b: got %h expected 0", bus_b());
      end
      reset = 1'b0; awaited = 1'b0;
      tick();
   endtask

   task automatic test_full_paint();
      sel = ID_A; awaited = 1'b1; #1;
      tests_run++;
      if (bus_a() !== '0) begin
         tests_failed++;
         $display("FAIL full_idle_cycle: got %h expected 0", bus_a());
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         #1;
         tests_run++;
         if (bus_a() !== pix(10 + k % 4, 5 + k / 4)) begin
            tests_failed++;
            $display("FAIL full_pix%0d: got %h expected %h", k, bus_a(), pix(10 + k % 4, 5 + k / 4));
         end
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (bus_a() !== '0) begin
            tests_failed++;
            $display("FAIL full_done_hold%0d: got %h expected 0", c, bus_a());
         end
         tick();
      end
      awaited = 1'b0; #1;
      tests_run++;
      if (bus_a() !== '0) begin
         tests_failed++;
         $display("FAIL full_grant_drop: got %h expected 0", bus_a());
      end
      tick();
   endtask

   task automatic test_not_selected();
      sel = ID_A - 2'd1; awaited = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests_run++;
         if ({bus_a(), bus_b()} !== '0) begin
            tests_failed++;
            $display("FAIL nsel_bus%0d: got a=%h b=%h expected 0", c, bus_a(), bus_b());
         end
         tick();
      end
      awaited = 1'b0;
      capture(ID_A);
      tests_run++;
      if (cap_first !== 1 || cap_n !== 8) begin
         tests_failed++;
         $display("FAIL nsel_still_idle: got first=%0d count=%0d expected first=1 count=8", cap_first, cap_n);
      end
      tests_run++;
      if (cap_bus[0] !== pix(10, 5)) begin
         tests_failed++;
         $display("FAIL nsel_origin: got %h expected %h", cap_bus[0], pix(10, 5));
      end
   endtask

   task automatic test_grant_gap();
      int n_act;
      n_act = 0;
      sel = ID_A; awaited = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            awaited = 1'b0;
            for (int c = 0; c < 3; c++) begin
               #1;
               n_act += int'(act_a);
               tests_run++;
               if (bus_a() !== '0) begin
                  tests_failed++;
                  $display("FAIL gap_bus%0d: got %h expected 0", c, bus_a());
               end
               tick();
            end
            awaited = 1'b1;
         end
         #1;
         n_act += int'(act_a);
         tests_run++;
         if (bus_a() !== pix(10 + k % 4, 5 + k / 4)) begin
            tests_failed++;
            $display("FAIL gap_pix%0d: got %h expected %h", k, bus_a(), pix(10 + k % 4, 5 + k / 4));
         end
         tick();
      end
      #1;
      n_act += int'(act_a);
      tests_run++;
      if (n_act !== 8) begin
         tests_failed++;
         $display("FAIL gap_count: got %0d expected 8", n_act);
      end
      awaited = 1'b0;
      tick(); tick();
   endtask

   task automatic test_frame_during_paint();
      wheel_a = 12'h15A;
      sel = ID_A; awaited = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         if (k == 3) frame_a = 1'b1;
         #1;
         tests_run++;
         if (bus_a() !== pix(10 + k % 4, 5 + k / 4)) begin
            tests_failed++;
            $display("FAIL fdp_pix%0d: got %h expected %h", k, bus_a(), pix(10 + k % 4, 5 + k / 4));
         end
         tick();
         frame_a = 1'b0;
      end
      awaited = 1'b0;
      tick(); tick();
      wheel_a = '0;
      capture(ID_A);
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (cap_bus[k] !== pix(11 + k % 4, 6 + k / 4)) begin
            tests_failed++;
            $display("FAIL fdp_next%0d: got %h expected %h", k, cap_bus[k], pix(11 + k % 4, 6 + k / 4));
         end
      end
   endtask

   task automatic test_bounce();
      int spd [11] = '{2, 2, 3, 3, 3, 3, 3, 2, 3, 0, 1};
      int ex  [11] = '{12, 14, 16, 13, 10, 7, 4, 2, 0, 0, 1};
      int ey  [11] = '{7, 8, 5, 2, 0, 3, 6, 8, 5, 5, 4};
      for (int i = 0; i < 11; i++) begin
         pulse_b(4'(spd[i]));
         capture(ID_B);
         tests_run++;
         if (cap_bus[0] !== pix(ex[i], ey[i])) begin
            tests_failed++;
            $display("FAIL bounce_first%0d: got %h expected %h", i, cap_bus[0], pix(ex[i], ey[i]));
         end
         tests_run++;
         if (cap_bus[7] !== pix(ex[i] + 3, ey[i] + 1)) begin
            tests_failed++;
            $display("FAIL bounce_last%0d: got %h expected %h", i, cap_bus[7], pix(ex[i] + 3, ey[i] + 1));
         end
      end
   endtask

   task automatic test_reset_mid_paint();
      sel = ID_A; awaited = 1'b1;
      tick();
      tick(); tick(); tick();
      #1;
      tests_run++;
      if (bus_a() !== pix(14, 6)) begin
         tests_failed++;
         $display("FAIL rmp_before: got %h expected %h", bus_a(), pix(14, 6));
      end
      reset = 1'b1; #1;
      tests_run++;
      if (bus_a() !== '0) begin
         tests_failed++;
         $display("FAIL rmp_async_bus: got %h expected 0", bus_a());
      end
      tick();
      reset = 1'b0; awaited = 1'b0;
      tick();
      capture(ID_A);
      tests_run++;
      if (cap_first !== 1 || cap_n !== 8) begin
         tests_failed++;
         $display("FAIL rmp_fresh: got first=%0d count=%0d expected first=1 count=8", cap_first, cap_n);
      end
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (cap_bus[k] !== pix(10 + k % 4, 5 + k / 4)) begin
            tests_failed++;
            $display("FAIL rmp_pix%0d: got %h expected %h", k, cap_bus[k], pix(10 + k % 4, 5 + k / 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_paint();
      test_not_selected();
      test_grant_gap();
      test_frame_during_paint();
      test_bounce();
      test_reset_mid_paint();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
